// File: rtl/game_pkg.sv
// Shared player-input definitions: button bit positions, vector width and
// the default choice of which buttons are delivered as one-cycle pulses.
// The game core decodes its player input port with these same constants.
package game_pkg;

  localparam int NUM_BTNS = 7;

  localparam int BTN_CENTER = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 4;
  localparam int BTN_ATTACK = 5;
  localparam int BTN_SHIELD = 6;

  typedef logic [NUM_BTNS-1:0] btn_vec_t;

  // Jump (up) and attack are actions, not held states.
  localparam btn_vec_t DEFAULT_PULSE_MASK = 7'b0101000;

endpackage

// File: rtl/button_debouncer.sv
// Single-button conditioner: 2-FF synchroniser, stable-state debounce
// counter, and rising/falling edge flags of the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_stable_p2;
  logic             r_stable_q;
  logic [CNT_W-1:0] r_cnt;

  // Stage p0/p1: bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= i_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Stage p2: accept a new level only after it has persisted for the full
  // debounce window; any return to the old level restarts the wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable_p2 <= 1'b0;
      r_cnt       <= '0;
    end else if (r_sync_p1 == r_stable_p2) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable_p2 <= ~r_stable_p2;
      r_cnt       <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Previous debounced level, for edge detection.
  always_ff @(posedge clk) begin
    if (reset) r_stable_q <= 1'b0;
    else       r_stable_q <= r_stable_p2;
  end

  assign o_stable = r_stable_p2;
  assign o_rise   = r_stable_p2 & ~r_stable_q;
  assign o_fall   = ~r_stable_p2 & r_stable_q;

endmodule

// File: rtl/input_encoder.sv
// Player input encoder: debounces the seven board buttons, turns selected
// buttons into one-cycle pulses, removes contradictory combinations and
// registers the result for the game core.
// Optional build macro INPUT_ENCODER_AUTOREPEAT_EN: pulse buttons re-fire
// every REPEAT_CYCLES while held (btn_pressed never repeats).
module input_encoder
  import game_pkg::*;
#(
  parameter int       DEBOUNCE_CYCLES = 1_000_000,
  parameter int       CNT_W           = 20,
  parameter btn_vec_t PULSE_MASK      = DEFAULT_PULSE_MASK,
  parameter int       REPEAT_CYCLES   = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] inputs_out,
  output logic [NUM_BTNS-1:0] btn_pressed,
  output logic [NUM_BTNS-1:0] btn_released
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W) - 1 ||
      REPEAT_CYCLES < 2) begin : g_bad_params
    $error("input_encoder: parameter out of legal range");
  end

  // Opposing directions cancel; shield overrides attack; center is untouched.
  // Detection uses the held levels so a pulse bit is blocked while its
  // opposite is held.
  function automatic btn_vec_t resolve_conflicts(input btn_vec_t enc,
                                                 input btn_vec_t lvl);
    btn_vec_t v;
    v = enc;
    if (lvl[BTN_LEFT] && lvl[BTN_RIGHT]) begin
      v[BTN_LEFT]  = 1'b0;
      v[BTN_RIGHT] = 1'b0;
    end
    if (lvl[BTN_UP] && lvl[BTN_DOWN]) begin
      v[BTN_UP]   = 1'b0;
      v[BTN_DOWN] = 1'b0;
    end
    if (lvl[BTN_SHIELD]) v[BTN_ATTACK] = 1'b0;
    return v;
  endfunction

  btn_vec_t w_stable;
  btn_vec_t w_rise;
  btn_vec_t w_fall;
  btn_vec_t w_enc;
  btn_vec_t r_inputs_out;
  btn_vec_t r_btn_pressed;
  btn_vec_t r_btn_released;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debouncer (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (btn_raw[g]),
      .o_stable (w_stable[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
    );
  end

`ifdef INPUT_ENCODER_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

  btn_vec_t w_repeat;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_rep
    if (PULSE_MASK[g]) begin : g_on
      logic [REP_W-1:0] r_rep_cnt;

      assign w_repeat[g] = w_stable[g] && (r_rep_cnt == REP_W'(REPEAT_CYCLES));

      // Counts held cycles since the last pulse; restarts on every pulse and
      // clears as soon as the button is released.
      always_ff @(posedge clk) begin
        if (reset || !w_stable[g])        r_rep_cnt <= '0;
        else if (w_rise[g] || w_repeat[g]) r_rep_cnt <= REP_W'(1);
        else                               r_rep_cnt <= r_rep_cnt + REP_W'(1);
      end
    end else begin : g_off
      assign w_repeat[g] = 1'b0;
    end
  end

  assign w_enc = (w_stable & ~PULSE_MASK) | ((w_rise | w_repeat) & PULSE_MASK);
`else
  assign w_enc = (w_stable & ~PULSE_MASK) | (w_rise & PULSE_MASK);
`endif

  // Output stage: every output is a flop so the game core sees clean timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inputs_out   <= '0;
      r_btn_pressed  <= '0;
      r_btn_released <= '0;
    end else begin
      r_inputs_out   <= resolve_conflicts(w_enc, w_stable);
      r_btn_pressed  <= w_rise;
      r_btn_released <= w_fall;
    end
  end

  assign inputs_out   = r_inputs_out;
  assign btn_pressed  = r_btn_pressed;
  assign btn_released = r_btn_released;

endmodule

// File: tb/tb_input_encoder.sv
// Bench for input_encoder with a short debounce window (16) and repeat
// period (40). Expected output values are queued with the cycle they must
// appear on and compared as each cycle completes.
`timescale 1ns/1ps
module tb_input_encoder;
  import game_pkg::*;

  localparam int D   = 16;
  localparam int R   = 40;
  localparam int DLY = D + 3;

  localparam int K_OUT = 0;
  localparam int K_PRS = 1;
  localparam int K_REL = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] btn_raw = '0;
  logic [6:0] inputs_out;
  logic [6:0] btn_pressed;
  logic [6:0] btn_released;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    int         kind;
    logic [6:0] mask;
    logic [6:0] val;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [6:0] act;

  input_encoder #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (20),
    .PULSE_MASK      (DEFAULT_PULSE_MASK),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .inputs_out   (inputs_out),
    .btn_pressed  (btn_pressed),
    .btn_released (btn_released)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input int kind, input logic [6:0] m,
                          input logic [6:0] v, input string n);
    exp_t x;
    int   i;
    x.cyc = c; x.kind = kind; x.mask = m; x.val = v; x.name = n;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, x);
  endtask

  task automatic push_quiet(input int c0, input int c1, input string n);
    for (int c = c0; c <= c1; c++)
      for (int k = 0; k < 3; k++) push_exp(c, k, 7'h7f, 7'h00, n);
  endtask

  task automatic test_reset();
    int t0;
    @(negedge clk);
    t0 = cyc;
    push_quiet(t0 + 1, t0 + 8, "reset_quiet");
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = (e.kind == K_OUT) ? inputs_out : (e.kind == K_PRS) ? btn_pressed : btn_released;
        checks++;
        if (e.cyc != cyc || (act & e.mask) !== e.val) begin
          errors++;
          $display("FAIL %s @%0d: got %b want %b (mask %b)", e.name, e.cyc, act & e.mask, e.val, e.mask);
        end
      end
      if (cyc == t0 + 3) reset = 1'b0;
    end
  endtask

  task automatic test_level_press();
    int t0;
    @(negedge clk);
    t0 = cyc;
    btn_raw[BTN_LEFT] = 1'b1;
    push_exp(t0 + DLY - 1, K_OUT, 7'h7f, 7'b0000000, "left_out_early");
    push_exp(t0 + DLY - 1, K_PRS, 7'h7f, 7'b0000000, "left_prs_early");
    push_exp(t0 + DLY,     K_OUT, 7'h7f, 7'b0000010, "left_out");
    push_exp(t0 + DLY,     K_PRS, 7'h7f, 7'b0000010, "left_prs");
    push_exp(t0 + DLY + 1, K_PRS, 7'h7f, 7'b0000000, "left_prs_once");
    push_exp(t0 + DLY + 1, K_OUT, 7'h7f, 7'b0000010, "left_out_held");
    push_exp(t0 + 30,      K_OUT, 7'h7f, 7'b0000010, "left_out_level");
    push_exp(t0 + 30,      K_REL, 7'h7f, 7'b0000000, "left_rel_none");
    push_exp(t0 + 32 + DLY - 1, K_OUT, 7'h7f, 7'b0000010, "left_out_before_rel");
    push_exp(t0 + 32 + DLY - 1, K_REL, 7'h7f, 7'b0000000, "left_rel_early");
    push_exp(t0 + 32 + DLY,     K_REL, 7'h7f, 7'b0000010, "left_rel");
    push_exp(t0 + 32 + DLY,     K_OUT, 7'h7f, 7'b0000000, "left_out_off");
    push_exp(t0 + 32 + DLY + 1, K_REL, 7'h7f, 7'b0000000, "left_rel_once");
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = (e.kind == K_OUT) ? inputs_out : (e.kind == K_PRS) ? btn_pressed : btn_released;
        checks++;
        if (e.cyc != cyc || (act & e.mask) !== e.val) begin
          errors++;
          $display("FAIL %s @%0d: got %b want %b (mask %b)", e.name, e.cyc, act & e.mask, e.val, e.mask);
        end
      end
      if (cyc == t0 + 32) btn_raw[BTN_LEFT] = 1'b0;
    end
  endtask

  task automatic test_glitch();
    int t0;
    @(negedge clk);
    t0 = cyc;
    btn_raw[BTN_ATTACK] = 1'b1;
    push_quiet(t0 + 1, t0 + 98, "glitch_quiet");
    push_exp(t0 + 99,  K_PRS, 7'h7f, 7'b0100000, "min_press_prs");
    push_exp(t0 + 99,  K_OUT, 7'h7f, 7'b0100000, "min_press_out");
    push_exp(t0 + 99,  K_REL, 7'h7f, 7'b0000000, "min_press_rel");
    push_quiet(t0 + 100, t0 + 114, "min_press_between");
    push_exp(t0 + 115, K_REL, 7'h7f, 7'b0100000, "min_press_rel_edge");
    push_exp(t0 + 115, K_OUT, 7'h7f, 7'b0000000, "min_press_out_off");
    push_exp(t0 + 115, K_PRS, 7'h7f, 7'b0000000, "min_press_prs_off");
    for (int k = 1; k <= 118; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = (e.kind == K_OUT) ? inputs_out : (e.kind == K_PRS) ? btn_pressed : btn_released;
        checks++;
        if (e.cyc != cyc || (act & e.mask) !== e.val) begin
          errors++;
          $display("FAIL %s @%0d: got %b want %b (mask %b)", e.name, e.cyc, act & e.mask, e.val, e.mask);
        end
      end
      if (cyc == t0 + 10) btn_raw[BTN_ATTACK] = 1'b0;
      if (cyc == t0 + 40) btn_raw[BTN_ATTACK] = 1'b1;
      if (cyc == t0 + 55) btn_raw[BTN_ATTACK] = 1'b0;
      if (cyc == t0 + 80) btn_raw[BTN_ATTACK] = 1'b1;
      if (cyc == t0 + 96) btn_raw[BTN_ATTACK] = 1'b0;
    end
  endtask

  task automatic test_pulse_hold();
    int   t0;
    logic rep;
    @(negedge clk);
    t0 = cyc;
    btn_raw[BTN_ATTACK] = 1'b1;
    for (int c = 1; c <= 125; c++) begin
      rep = 1'b0;
`ifdef INPUT_ENCODER_AUTOREPEAT_EN
      rep = (c == DLY + R) || (c == DLY + 2 * R);
`endif
      push_exp(t0 + c, K_OUT, 7'b0100000, (c == DLY || rep) ? 7'b0100000 : 7'b0000000, "attack_out");
      push_exp(t0 + c, K_PRS, 7'b0100000, (c == DLY) ? 7'b0100000 : 7'b0000000, "attack_prs");
      push_exp(t0 + c, K_REL, 7'b0100000, (c == 100 + DLY) ? 7'b0100000 : 7'b0000000, "attack_rel");
    end
    for (int k = 1; k <= 126; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = (e.kind == K_OUT) ? inputs_out : (e.kind == K_PRS) ? btn_pressed : btn_released;
        checks++;
        if (e.cyc != cyc || (act & e.mask) !== e.val) begin
          errors++;
          $display("FAIL %s @%0d: got %b want %b (mask %b)", e.name, e.cyc, act & e.mask, e.val, e.mask);
        end
      end
      if (cyc == t0 + 100) btn_raw[BTN_ATTACK] = 1'b0;
    end
  endtask

  task automatic test_conflicts();
    int t0;
    @(negedge clk);
    t0 = cyc;
    btn_raw = 7'b0011111;
    push_exp(t0 + DLY,      K_PRS, 7'h7f, 7'b0011111, "dir_prs");
    push_exp(t0 + DLY,      K_OUT, 7'h7f, 7'b0000001, "dir_out_masked");
    push_exp(t0 + 25,       K_OUT, 7'h7f, 7'b0000001, "dir_out_held");
    push_exp(t0 + 30 + DLY, K_PRS, 7'h7f, 7'b1100000, "atk_sh_prs");
    push_exp(t0 + 30 + DLY, K_OUT, 7'h7f, 7'b1000001, "shield_wins");
    push_exp(t0 + 55,       K_OUT, 7'h7f, 7'b1000001, "shield_held");
    push_exp(t0 + 60 + DLY, K_REL, 7'h7f, 7'b1111111, "all_rel");
    push_exp(t0 + 60 + DLY, K_OUT, 7'h7f, 7'b0000000, "all_out_off");
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = (e.kind == K_OUT) ? inputs_out : (e.kind == K_PRS) ? btn_pressed : btn_released;
        checks++;
        if (e.cyc != cyc || (act & e.mask) !== e.val) begin
          errors++;
          $display("FAIL %s @%0d: got %b want %b (mask %b)", e.name, e.cyc, act & e.mask, e.val, e.mask);
        end
      end
      if (cyc == t0 + 30) btn_raw = 7'b1111111;
      if (cyc == t0 + 60) btn_raw = 7'b0000000;
    end
  endtask

  task automatic test_up_release();
    int t0;
    @(negedge clk);
    t0 = cyc;
    btn_raw[BTN_UP] = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      push_exp(t0 + c, K_OUT, 7'b0001000, (c == DLY) ? 7'b0001000 : 7'b0000000, "up_out");
      push_exp(t0 + c, K_PRS, 7'b0001000, (c == DLY) ? 7'b0001000 : 7'b0000000, "up_prs");
      push_exp(t0 + c, K_REL, 7'b0001000, (c == 30 + DLY) ? 7'b0001000 : 7'b0000000, "up_rel");
    end
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = (e.kind == K_OUT) ? inputs_out : (e.kind == K_PRS) ? btn_pressed : btn_released;
        checks++;
        if (e.cyc != cyc || (act & e.mask) !== e.val) begin
          errors++;
          $display("FAIL %s @%0d: got %b want %b (mask %b)", e.name, e.cyc, act & e.mask, e.val, e.mask);
        end
      end
      if (cyc == t0 + 30) btn_raw[BTN_UP] = 1'b0;
    end
  endtask

  task automatic test_reset_pending();
    int t0;
    @(negedge clk);
    t0 = cyc;
    btn_raw[BTN_RIGHT] = 1'b1;
    push_quiet(t0 + 1, t0 + 13 + DLY - 1, "rst_pend_quiet");
    push_exp(t0 + 13 + DLY,     K_PRS, 7'h7f, 7'b0000100, "rst_pend_prs");
    push_exp(t0 + 13 + DLY,     K_OUT, 7'h7f, 7'b0000100, "rst_pend_out");
    push_exp(t0 + 13 + DLY + 1, K_PRS, 7'h7f, 7'b0000000, "rst_pend_prs_once");
    push_exp(t0 + 40 + DLY,     K_REL, 7'h7f, 7'b0000100, "rst_pend_rel");
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = (e.kind == K_OUT) ? inputs_out : (e.kind == K_PRS) ? btn_pressed : btn_released;
        checks++;
        if (e.cyc != cyc || (act & e.mask) !== e.val) begin
          errors++;
          $display("FAIL %s @%0d: got %b want %b (mask %b)", e.name, e.cyc, act & e.mask, e.val, e.mask);
        end
      end
      if (cyc == t0 + 10) reset = 1'b1;
      if (cyc == t0 + 13) reset = 1'b0;
      if (cyc == t0 + 40) btn_raw[BTN_RIGHT] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_level_press();
    test_glitch();
    test_pulse_hold();
    test_conflicts();
    test_up_release();
    test_reset_pending();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s @%0d: expectation never compared (want %b)", e.name, e.cyc, e.val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
